// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN frame sink.
// Holds the default field widths and the FSM state encoding used by
// cnn_frame_sink and its address generator.
package cnn_pkg;

  localparam int unsigned DefWSize = 12;
  localparam int unsigned DefWData = 24;
  localparam int unsigned DefWAddr = 32;

  // DONE needs a fifth code, so the state register is 3 bits wide.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StVsync   = 3'd1,
    StData    = 3'd2,
    StLineGap = 3'd3,
    StDone    = 3'd4
  } state_e;

endpackage

// File: rtl/cnn_sink_addr_gen.sv
// Row/column/pixel-index counters for the CNN frame sink.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   clear_i            drop the current frame position (abort)
//   accept_i           one pixel accepted this cycle
//   width_i, height_i  frame geometry
//   base_i             output buffer base address
//   row_o, col_o       position of the next expected pixel
//   last_o             the next expected pixel is the last of the frame
//   addr_o             base_i + index, wraps modulo 2^W_ADDR
module cnn_sink_addr_gen
  import cnn_pkg::*;
#(
  parameter int unsigned W_SIZE       = DefWSize,
  parameter int unsigned W_FRAME_SIZE = 2 * W_SIZE + 1,
  parameter int unsigned W_ADDR       = DefWAddr
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [W_SIZE-1:0] width_i,
  input  logic [W_SIZE-1:0] height_i,
  input  logic [W_ADDR-1:0] base_i,
  output logic [W_SIZE-1:0] row_o,
  output logic [W_SIZE-1:0] col_o,
  output logic              last_o,
  output logic [W_ADDR-1:0] addr_o
);

  logic [W_SIZE-1:0]       row_q, row_d;
  logic [W_SIZE-1:0]       col_q, col_d;
  logic [W_FRAME_SIZE-1:0] index_q, index_d;
  logic [W_FRAME_SIZE-1:0] total;
  logic                    col_last;

  // W_FRAME_SIZE holds the full product, so this never overflows.
  assign total    = W_FRAME_SIZE'(width_i) * W_FRAME_SIZE'(height_i);
  assign last_o   = (index_q == total - W_FRAME_SIZE'(1));
  assign col_last = (col_q == width_i - W_SIZE'(1));

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    index_d = index_q;
    if (clear_i) begin
      row_d   = '0;
      col_d   = '0;
      index_d = '0;
    end else if (accept_i) begin
      if (last_o) begin
        row_d   = '0;
        col_d   = '0;
        index_d = '0;
      end else begin
        index_d = index_q + W_FRAME_SIZE'(1);
        if (col_last) begin
          col_d = '0;
          row_d = row_q + W_SIZE'(1);
        end else begin
          col_d = col_q + W_SIZE'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q   <= '0;
      col_q   <= '0;
      index_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      index_q <= index_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = base_i + W_ADDR'(index_q);

endmodule

// File: rtl/cnn_frame_sink.sv
// Receiving end of the CNN frame-timing interface. Tracks the incoming
// vsync/hsync/data strobes, turns every accepted pixel into a registered
// write to the output buffer at base + index, and pulses o_frame_done once
// the last pixel of a frame has been written.
// Optional protocol checker: define CNN_SINK_PROTO_CHK_EN to enable the
// sticky o_err_line/o_err_frame flags and mid-frame vsync abort.
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   q_width, q_height             frame geometry (stable while o_busy)
//   q_base_addr                   output buffer base address
//   q_clr_err                     clear sticky error flags
//   i_vsync_run/i_hsync_run       sender sync periods
//   i_data_run, i_data            pixel strobe and data
//   o_wr_en/o_wr_addr/o_wr_data   output memory write, 1 cycle after accept
//   o_row, o_col                  position of the next expected pixel
//   o_busy                        frame in progress
//   o_frame_done                  1-cycle pulse after the last write
//   o_err_line, o_err_frame       sticky protocol errors
module cnn_frame_sink
  import cnn_pkg::*;
#(
  parameter int unsigned W_SIZE       = DefWSize,
  parameter int unsigned W_FRAME_SIZE = 2 * W_SIZE + 1,
  parameter int unsigned W_DATA       = DefWData,
  parameter int unsigned W_ADDR       = DefWAddr
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [W_SIZE-1:0] q_width,
  input  logic [W_SIZE-1:0] q_height,
  input  logic [W_ADDR-1:0] q_base_addr,
  input  logic              q_clr_err,
  input  logic              i_vsync_run,
  input  logic              i_hsync_run,
  input  logic              i_data_run,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_wr_en,
  output logic [W_ADDR-1:0] o_wr_addr,
  output logic [W_DATA-1:0] o_wr_data,
  output logic [W_SIZE-1:0] o_row,
  output logic [W_SIZE-1:0] o_col,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err_line,
  output logic              o_err_frame
);

  state_e            state_q, state_d;
  logic              accept;
  logic              abort;
  logic              last_pix;
  logic [W_ADDR-1:0] addr;
  logic [W_SIZE-1:0] row, col;

  logic              wr_en_q;
  logic [W_ADDR-1:0] wr_addr_q;
  logic [W_DATA-1:0] wr_data_q;
  logic              done_q;

  assign accept = i_data_run && !abort &&
                  (state_q == StVsync || state_q == StData || state_q == StLineGap);

  cnn_sink_addr_gen #(
    .W_SIZE       (W_SIZE),
    .W_FRAME_SIZE (W_FRAME_SIZE),
    .W_ADDR       (W_ADDR)
  ) u_addr_gen (
    .clk      (clk),
    .rstn     (rstn),
    .clear_i  (abort),
    .accept_i (accept),
    .width_i  (q_width),
    .height_i (q_height),
    .base_i   (q_base_addr),
    .row_o    (row),
    .col_o    (col),
    .last_o   (last_pix),
    .addr_o   (addr)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (i_vsync_run) state_d = StVsync;
      end
      StVsync, StData, StLineGap: begin
        // A 1x1 frame finishes on the pixel taken straight out of VSYNC.
        if (accept && last_pix)    state_d = StDone;
        else if (accept)           state_d = StData;
        else if (state_q == StData) state_d = StLineGap;
        if (abort)                 state_d = StVsync;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= addr;
        wr_data_q <= i_data;
      end
      done_q <= (state_q == StDone);
    end
  end

`ifdef CNN_SINK_PROTO_CHK_EN
  logic vsync_q;
  logic hsync_seen_q;
  logic err_line_q, err_frame_q;
  logic set_line, set_frame;

  always_comb begin
    set_frame = i_vsync_run && !vsync_q && (state_q == StData || state_q == StLineGap);
    abort     = set_frame;
    // Short line: the run ended before col wrapped back to 0.
    // Run-on line: col wrapped during an unbroken run with no hsync since the last pixel.
    set_line  = (state_q == StData && !i_data_run && col != '0) ||
                (accept && state_q == StData && col == '0 && row != '0 &&
                 !(hsync_seen_q || i_hsync_run));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_q      <= 1'b0;
      hsync_seen_q <= 1'b0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      vsync_q      <= i_vsync_run;
      hsync_seen_q <= i_hsync_run | (hsync_seen_q & ~accept);
      // Set wins over a same-cycle clear.
      err_line_q   <= (err_line_q & ~q_clr_err) | set_line;
      err_frame_q  <= (err_frame_q & ~q_clr_err) | set_frame;
    end
  end

  assign o_err_line  = err_line_q;
  assign o_err_frame = err_frame_q;
`else
  logic unused_chk;

  assign abort       = 1'b0;
  assign unused_chk  = ^{i_hsync_run, q_clr_err};
  assign o_err_line  = 1'b0;
  assign o_err_frame = 1'b0;
`endif

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_row        = row;
  assign o_col        = col;
  assign o_busy       = (state_q != StIdle);
  assign o_frame_done = done_q;

endmodule
